// File: rtl/npc_unit_pkg.sv
// Shared constants for the next-PC unit: reset/exception addresses, fetch window, FSM encoding.
package npc_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
    localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [XLEN-1:0] IM_LO      = 32'h0000_3000;
    localparam logic [XLEN-1:0] IM_HI      = 32'h0000_6FFF;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/npc_unit_if.sv
// Redirect requests from ID/M into the next-PC unit and the fetch address it returns to IF.
interface npc_unit_if;
    import npc_unit_pkg::*;

    logic            stall;
    logic            id_is_branch;
    logic            id_jump;
    logic            id_is_j;
    logic            id_is_jr;
    logic [XLEN-1:0] id_pc;
    logic [15:0]     id_imm16;
    logic [25:0]     id_imm26;
    logic [XLEN-1:0] id_rs_val;
    logic            exc_req;
    logic            eret_req;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] if_pc;
    logic            if_valid;
    logic            if_adel;
    logic            redirect;

    modport master (
        output stall, id_is_branch, id_jump, id_is_j, id_is_jr, id_pc,
               id_imm16, id_imm26, id_rs_val, exc_req, eret_req, epc,
        input  if_pc, if_valid, if_adel, redirect
    );

    modport slave (
        input  stall, id_is_branch, id_jump, id_is_j, id_is_jr, id_pc,
               id_imm16, id_imm26, id_rs_val, exc_req, eret_req, epc,
        output if_pc, if_valid, if_adel, redirect
    );

endinterface

// File: rtl/npc_unit_target.sv
// Combinational branch/jump target computation and next-PC priority mux.
module npc_target
    import npc_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            id_is_branch,
    input  logic            id_jump,
    input  logic            id_is_j,
    input  logic            id_is_jr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [15:0]     id_imm16,
    input  logic [25:0]     id_imm26,
    input  logic [XLEN-1:0] id_rs_val,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] npc_c,
    output logic            redirect_c,
    output logic            taken_c
);

    logic [XLEN-1:0] id_pc4;
    logic [XLEN-1:0] br_off;

    assign id_pc4 = id_pc + XLEN'(4);
    assign br_off = {{14{id_imm16[15]}}, id_imm16, 2'b00};

    // Exception and eret sit above stall so they can break a held pipeline.
    always_comb begin
        npc_c      = pc + XLEN'(4);
        redirect_c = FALSE;
        taken_c    = FALSE;
        if (exc_req) begin
            npc_c      = EXC_VECTOR;
            redirect_c = TRUE;
        end else if (eret_req) begin
            npc_c      = epc;
            redirect_c = TRUE;
        end else if (stall) begin
            npc_c = pc;
        end else if (id_is_branch && id_jump) begin
            npc_c      = id_pc4 + br_off;
            redirect_c = TRUE;
            taken_c    = TRUE;
        end else if (id_is_j) begin
            npc_c      = {id_pc4[31:28], id_imm26, 2'b00};
            redirect_c = TRUE;
        end else if (id_is_jr) begin
            npc_c      = id_rs_val;
            redirect_c = TRUE;
        end
    end

endmodule

// File: rtl/npc_unit.sv
// Fetch PC register, BOOT/RUN/HOLD FSM and fetch address-error flag.
// Optional NPC_STAT_EN adds saturating taken-branch and redirect counters.
module npc_unit
    import npc_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    npc_unit_if.slave       bus
`ifdef NPC_STAT_EN
    ,
    output logic [XLEN-1:0] stat_taken,
    output logic [XLEN-1:0] stat_redirect
`endif
);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            redirect_q;
    logic [XLEN-1:0] npc_c;
    logic            redirect_c;
    logic            taken_c;
    logic            hold_c;

    npc_target u_target (
        .pc          (pc_q),
        .stall       (bus.stall),
        .id_is_branch(bus.id_is_branch),
        .id_jump     (bus.id_jump),
        .id_is_j     (bus.id_is_j),
        .id_is_jr    (bus.id_is_jr),
        .id_pc       (bus.id_pc),
        .id_imm16    (bus.id_imm16),
        .id_imm26    (bus.id_imm26),
        .id_rs_val   (bus.id_rs_val),
        .exc_req     (bus.exc_req),
        .eret_req    (bus.eret_req),
        .epc         (bus.epc),
        .npc_c       (npc_c),
        .redirect_c  (redirect_c),
        .taken_c     (taken_c)
    );

    assign hold_c = bus.stall && !bus.exc_req && !bus.eret_req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (hold_c)  state_d = ST_HOLD;
            ST_HOLD: if (!hold_c) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // BOOT keeps the reset PC for one edge so the first real fetch is RESET_PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= FALSE;
            redirect_q <= FALSE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BOOT) begin
                pc_q       <= RESET_PC;
                valid_q    <= TRUE;
                redirect_q <= FALSE;
            end else begin
                pc_q       <= npc_c;
                redirect_q <= redirect_c;
            end
        end
    end

    assign bus.if_pc    = pc_q;
    assign bus.if_valid = valid_q;
    assign bus.redirect = redirect_q;
    assign bus.if_adel  = valid_q && ((pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI));

`ifdef NPC_STAT_EN
    logic            active_c;
    logic [XLEN-1:0] taken_q;
    logic [XLEN-1:0] redir_cnt_q;

    assign active_c = (state_q != ST_BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q     <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (active_c && taken_c && (taken_q != '1))
                taken_q <= taken_q + XLEN'(1);
            if (active_c && redirect_c && (redir_cnt_q != '1))
                redir_cnt_q <= redir_cnt_q + XLEN'(1);
        end
    end

    assign stat_taken    = taken_q;
    assign stat_redirect = redir_cnt_q;
`endif

endmodule
